// File: rtl/regn_pipe.sv
`default_nettype none
// ============================================================================
// Module  : regn_pipe
// Brief   : Elastic DEPTH-stage, N-bit register pipeline with valid/ready on
//           both sides; empty stages collapse so data fills bubbles.
// Revision: 1.0  initial release
// ============================================================================
module regn_pipe #(
    parameter  int N     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  R,
    input  logic          Rvalid,
    output logic          Rready,
    input  logic          Flush,
    output logic [N-1:0]  Q,
    output logic          Qvalid,
    input  logic          Qready,
    output logic [CW-1:0] Count
);

    logic [DEPTH-1:0] w_valid;
    logic [N-1:0]     w_data [DEPTH];
    logic [DEPTH:0]   w_rdy;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

    // A stage can load when it is empty or its downstream neighbour can load.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = Qready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_valid[k] | w_rdy[k+1];
        end
    end

    assign Rready     = w_rdy[0] & ~Flush & ~Reset;
    assign w_in_xfer  = Rvalid & Rready;
    assign w_out_xfer = w_valid[DEPTH-1] & Qready;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic         w_vin;
            logic [N-1:0] w_din;
            logic         r_v;
            logic [N-1:0] r_d;

            if (k == 0) begin : g_head
                assign w_vin = w_in_xfer;
                assign w_din = R;
            end else begin : g_body
                assign w_vin = w_valid[k-1];
                assign w_din = w_data[k-1];
            end

            // Data only moves with a valid word, so Q holds after the last word leaves.
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_v <= 1'b0;
                    r_d <= '0;
                end else if (Flush) begin
                    r_v <= 1'b0;
                end else if (w_rdy[k]) begin
                    r_v <= w_vin;
                    if (w_vin) begin
                        r_d <= w_din;
                    end
                end
            end

            assign w_valid[k] = r_v;
            assign w_data[k]  = r_d;
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign Q      = w_data[DEPTH-1];
    assign Qvalid = w_valid[DEPTH-1];
    assign Count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regn_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_regn_pipe
// Brief   : Scoreboard bench for regn_pipe: directed vectors on N=8/DEPTH=4,
//           random traffic on that instance and on N=32/DEPTH=1, N=1/DEPTH=2.
// Revision: 1.0  initial release
// ============================================================================
module tb_regn_pipe;

    logic        Clock;
    logic        Reset;

    logic [7:0]  R0, Q0;
    logic        Rvalid0, Rready0, Flush0, Qvalid0, Qready0;
    logic [2:0]  Count0;

    logic [31:0] R1, Q1;
    logic        Rvalid1, Rready1, Flush1, Qvalid1, Qready1;
    logic        Count1;

    logic        R2, Q2;
    logic        Rvalid2, Rready2, Flush2, Qvalid2, Qready2;
    logic [1:0]  Count2;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    regn_pipe #(.N(8), .DEPTH(4)) u0 (
        .Clock(Clock), .Reset(Reset), .R(R0), .Rvalid(Rvalid0), .Rready(Rready0),
        .Flush(Flush0), .Q(Q0), .Qvalid(Qvalid0), .Qready(Qready0), .Count(Count0)
    );
    regn_pipe #(.N(32), .DEPTH(1)) u1 (
        .Clock(Clock), .Reset(Reset), .R(R1), .Rvalid(Rvalid1), .Rready(Rready1),
        .Flush(Flush1), .Q(Q1), .Qvalid(Qvalid1), .Qready(Qready1), .Count(Count1)
    );
    regn_pipe #(.N(1), .DEPTH(2)) u2 (
        .Clock(Clock), .Reset(Reset), .R(R2), .Rvalid(Rvalid2), .Rready(Rready2),
        .Flush(Flush2), .Q(Q2), .Qvalid(Qvalid2), .Qready(Qready2), .Count(Count2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spurious(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=output-transfer required=empty-scoreboard at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    always @(posedge Reset) begin
        q0.delete();
        q1.delete();
        q2.delete();
    end

    // Monitors sample mid-cycle: Count reflects the last edge, handshakes the next one.
    always @(negedge Clock) begin
        if (Reset) begin
            q0.delete();
        end else begin
            chk("count0", 64'(Count0), 64'(q0.size()));
            if (Qvalid0 && Qready0) begin
                if (q0.size() == 0) spurious("out0");
                else chk("q0", 64'(Q0), 64'(q0.pop_front()));
            end
            if (Flush0) q0.delete();
            else if (Rvalid0 && Rready0) q0.push_back(32'(R0));
        end
    end

    always @(negedge Clock) begin
        if (Reset) begin
            q1.delete();
        end else begin
            chk("count1", 64'(Count1), 64'(q1.size()));
            if (Qvalid1 && Qready1) begin
                if (q1.size() == 0) spurious("out1");
                else chk("q1", 64'(Q1), 64'(q1.pop_front()));
            end
            if (Flush1) q1.delete();
            else if (Rvalid1 && Rready1) q1.push_back(R1);
        end
    end

    always @(negedge Clock) begin
        if (Reset) begin
            q2.delete();
        end else begin
            chk("count2", 64'(Count2), 64'(q2.size()));
            if (Qvalid2 && Qready2) begin
                if (q2.size() == 0) spurious("out2");
                else chk("q2", 64'(Q2), 64'(q2.pop_front()));
            end
            if (Flush2) q2.delete();
            else if (Rvalid2 && Rready2) q2.push_back(32'(R2));
        end
    end

    initial begin
        Reset = 1'b0;
        {R0, Rvalid0, Flush0, Qready0} = '0;
        {R1, Rvalid1, Flush1, Qready1} = '0;
        {R2, Rvalid2, Flush2, Qready2} = '0;
        #1 Reset = 1'b1;
        #1;
        chk("rst_q",      64'(Q0),      64'h0);
        chk("rst_qvalid", 64'(Qvalid0), 64'h0);
        chk("rst_count",  64'(Count0),  64'h0);
        chk("rst_rready", 64'(Rready0), 64'h0);
        step();
        step();
        Reset = 1'b0;
        #1 chk("rel_rready", 64'(Rready0), 64'h1);

        // Streaming with consumer always ready
        Qready0 = 1'b1;
        R0 = 8'h11; Rvalid0 = 1'b1;
        #1 chk("t1_rready", 64'(Rready0), 64'h1);
        step();
        R0 = 8'h22; step();
        R0 = 8'h33; step();
        Rvalid0 = 1'b0;
        chk("t1_count_peak", 64'(Count0), 64'h3);
        chk("t1_not_yet", 64'(Qvalid0), 64'h0);
        step();
        chk("t1_qvalid", 64'(Qvalid0), 64'h1);
        chk("t1_q11", 64'(Q0), 64'h11);
        step(); chk("t1_q22", 64'(Q0), 64'h22);
        step(); chk("t1_q33", 64'(Q0), 64'h33);
        step();
        chk("t1_empty", 64'(Qvalid0), 64'h0);
        chk("t1_hold", 64'(Q0), 64'h33);

        // Stalled consumer fills the pipe
        Qready0 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            R0 = 8'(i); Rvalid0 = 1'b1;
            step();
            if (i == 4) begin
                chk("t2_count_full", 64'(Count0), 64'h4);
                chk("t2_q01", 64'(Q0), 64'h01);
                #1 chk("t2_rready_full", 64'(Rready0), 64'h0);
            end
        end
        chk("t2_q_stable", 64'(Q0), 64'h01);
        chk("t2_qvalid", 64'(Qvalid0), 64'h1);
        chk("t2_count", 64'(Count0), 64'h4);

        // Full with simultaneous in and out transfer
        R0 = 8'h07; Rvalid0 = 1'b1; Qready0 = 1'b1;
        #1 chk("t3_rready", 64'(Rready0), 64'h1);
        step();
        Rvalid0 = 1'b0;
        chk("t3_count", 64'(Count0), 64'h4);
        chk("t3_q02", 64'(Q0), 64'h02);
        repeat (4) step();
        chk("t3_drained", 64'(Count0), 64'h0);
        chk("t3_qvalid", 64'(Qvalid0), 64'h0);
        chk("t3_hold", 64'(Q0), 64'h07);

        // Bubbles collapse while the output is stalled
        Qready0 = 1'b0;
        R0 = 8'hAA; Rvalid0 = 1'b1; step();
        Rvalid0 = 1'b0; step(); step();
        R0 = 8'hBB; Rvalid0 = 1'b1; step();
        Rvalid0 = 1'b0; step(); step();
        chk("t4_count", 64'(Count0), 64'h2);
        chk("t4_qaa", 64'(Q0), 64'hAA);
        Qready0 = 1'b1; step();
        Qready0 = 1'b0;
        chk("t4_qbb_adjacent", 64'(Q0), 64'hBB);
        chk("t4_qvalid", 64'(Qvalid0), 64'h1);

        // Flush with Count=3 and a word on offer
        R0 = 8'hC1; Rvalid0 = 1'b1; step();
        R0 = 8'hC2; step();
        chk("t5_count3", 64'(Count0), 64'h3);
        R0 = 8'hEE; Flush0 = 1'b1;
        #1 chk("t5_rready", 64'(Rready0), 64'h0);
        step();
        Flush0 = 1'b0; Rvalid0 = 1'b0;
        chk("t5_count", 64'(Count0), 64'h0);
        chk("t5_qvalid", 64'(Qvalid0), 64'h0);
        chk("t5_qhold", 64'(Q0), 64'hBB);

        // Asynchronous reset between edges
        R0 = 8'h55; Rvalid0 = 1'b1; step();
        R0 = 8'h66; step();
        Rvalid0 = 1'b0;
        chk("t6_count2", 64'(Count0), 64'h2);
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1;
        chk("t6_q", 64'(Q0), 64'h0);
        chk("t6_qvalid", 64'(Qvalid0), 64'h0);
        chk("t6_count", 64'(Count0), 64'h0);
        chk("t6_rready", 64'(Rready0), 64'h0);
        step();
        Reset = 1'b0;
        #1;
        R0 = 8'h77; Rvalid0 = 1'b1; Qready0 = 1'b1;
        #1 chk("t6_rready_rel", 64'(Rready0), 64'h1);
        step();
        Rvalid0 = 1'b0;
        step(); step();
        chk("t6_latency_early", 64'(Qvalid0), 64'h0);
        step();
        chk("t6_latency", 64'(Qvalid0), 64'h1);
        chk("t6_q77", 64'(Q0), 64'h77);
        step();

        // Random traffic on all three geometries
        for (int c = 0; c < 600; c++) begin
            R0 = 8'($urandom);  Rvalid0 = 1'($urandom_range(0, 1)); Qready0 = 1'($urandom_range(0, 1));
            Flush0 = ($urandom_range(0, 31) == 0);
            R1 = $urandom;      Rvalid1 = 1'($urandom_range(0, 1)); Qready1 = 1'($urandom_range(0, 1));
            Flush1 = ($urandom_range(0, 31) == 0);
            R2 = 1'($urandom);  Rvalid2 = 1'($urandom_range(0, 1)); Qready2 = 1'($urandom_range(0, 1));
            Flush2 = ($urandom_range(0, 31) == 0);
            step();
        end
        {Rvalid0, Flush0, Rvalid1, Flush1, Rvalid2, Flush2} = '0;
        {Qready0, Qready1, Qready2} = 3'b111;
        repeat (8) step();
        chk("drain0", 64'(q0.size()), 64'h0);
        chk("drain1", 64'(q1.size()), 64'h0);
        chk("drain2", 64'(q2.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
